ram_bus_arbiter: RTL and testbench

- Arbitrates the single RAM port among the instruction and data cache requesters of all cores. It runs in front of the coherence controller.
- Cores are served round-robin; within one core, data requests beat instruction requests.
- A data grant is locked for a block burst of BURST_LEN words, so cache-block fills and writebacks are never interleaved with another requester.
- The arbiter owns the ramREN/ramWEN/ramaddr/ramstore and iwait/dwait sequencing. Coherence snooping stays outside this block.

---
 rtl/ram_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter.sv
// Round-robin RAM port arbiter for per-core icache/dcache requesters.
// Data requests win within a core and hold the port for a full block burst.
package ram_bus_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_bus_arbiter
    import ram_bus_pkg::*;
#(
    parameter int CPUS      = 2,
    parameter int BURST_LEN = 2,
    parameter int AW        = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0][AW-1:0]  iaddr,
    input  logic [CPUS-1:0][AW-1:0]  daddr,
    input  logic [CPUS-1:0][AW-1:0]  dstore,
    input  ramstate_t                ramstate,
    input  logic [AW-1:0]            ramload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [AW-1:0]            ramaddr,
    output logic [AW-1:0]            ramstore,
    output logic [CPUS-1:0][AW-1:0]  iload,
    output logic [CPUS-1:0][AW-1:0]  dload,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic                     grant_valid,
    output logic [$clog2(CPUS):0]    grant_id,
    output logic                     bus_err
);
    localparam int CW = $clog2(CPUS);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE_GAP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   rr_ptr, rr_ptr_n;
    logic [BW-1:0]   beat_cnt, beat_cnt_n;
    logic [CW:0]     gid_n;
    logic [CPUS-1:0] req;
    logic [CW-1:0]   oc;
    logic            od;
    logic            oreq;
    logic            rel;
    logic            win_found;
    logic [CW-1:0]   win_core;
    logic            win_data;
    logic [CW-1:0]   ci;

    assign req         = iREN | dREN | dWEN;
    assign oc          = grant_id[CW:1];
    assign od          = grant_id[0];
    assign grant_valid = (state == GRANT);

    always_comb begin
        win_found = 1'b0;
        win_core  = '0;
        win_data  = 1'b0;
        ci        = '0;
        for (int k = 0; k < CPUS; k++) begin
            ci = CW'((int'(rr_ptr) + k) % CPUS);
            if (!win_found && req[ci]) begin
                win_found = 1'b1;
                win_core  = ci;
                win_data  = dREN[ci] | dWEN[ci];
            end
        end
    end

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        gid_n      = grant_id;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iload      = '0;
        dload      = '0;
        iwait      = '1;
        dwait      = '1;
        bus_err    = 1'b0;
        rel        = 1'b0;
        oreq       = od ? (dREN[oc] | dWEN[oc]) : iREN[oc];
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_n    = GRANT;
                    gid_n      = {win_core, win_data};
                    beat_cnt_n = '0;
                end
            end
            GRANT: begin
                ramaddr  = od ? daddr[oc] : iaddr[oc];
                ramstore = dstore[oc];
                ramREN   = !od || (dREN[oc] && !dWEN[oc]);
                ramWEN   = od && dWEN[oc];
                if (ramstate == ERROR) begin
                    bus_err = 1'b1;
                    rel     = 1'b1;
                end else if (!oreq) begin
                    rel = 1'b1;
                end else if (ramstate == ACCESS) begin
                    if (od) begin
                        dwait[oc] = 1'b0;
                        dload[oc] = ramload;
                    end else begin
                        iwait[oc] = 1'b0;
                        iload[oc] = ramload;
                    end
                    beat_cnt_n = beat_cnt + 1'b1;
                    rel = !od || (beat_cnt_n == BW'(BURST_LEN));
                end
                if (rel) begin
                    state_n    = RELEASE_GAP;
                    rr_ptr_n   = (oc == CW'(CPUS - 1)) ? '0 : oc + 1'b1;
                    gid_n      = '0;
                    beat_cnt_n = '0;
                end
            end
            RELEASE_GAP: state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
            grant_id <= gid_n;
        end
    end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Random and directed bench for ram_bus_arbiter against a
// transaction-level owner/gap/pointer model.
module tb_ram_bus_arbiter;
    import ram_bus_pkg::*;

    localparam int CPUS      = 2;
    localparam int BURST_LEN = 2;
    localparam int AW        = 32;

    logic                    CLK = 1'b0;
    logic                    nRST;
    logic [CPUS-1:0]         iREN, dREN, dWEN;
    logic [CPUS-1:0][AW-1:0] iaddr, daddr, dstore;
    ramstate_t               ramstate;
    logic [AW-1:0]           ramload;
    logic                    ramREN, ramWEN;
    logic [AW-1:0]           ramaddr, ramstore;
    logic [CPUS-1:0][AW-1:0] iload, dload;
    logic [CPUS-1:0]         iwait, dwait;
    logic                    grant_valid;
    logic [1:0]              grant_id;
    logic                    bus_err;

    ram_bus_arbiter #(
        .CPUS(CPUS), .BURST_LEN(BURST_LEN), .AW(AW)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .iload(iload), .dload(dload),
        .iwait(iwait), .dwait(dwait),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // model: who owns the port, beats delivered, gap pending, rr start
    bit m_own;
    int m_core;
    bit m_data;
    int m_beats;
    bit m_gap;
    int m_ptr;

    task automatic model_reset();
        m_own = 0; m_core = 0; m_data = 0;
        m_beats = 0; m_gap = 0; m_ptr = 0;
    endtask

    function automatic bit owner_req();
        if (m_data) return dREN[m_core] | dWEN[m_core];
        return iREN[m_core];
    endfunction

    task automatic model_release();
        m_own = 0;
        m_gap = 1;
        m_ptr = (m_core + 1) % CPUS;
    endtask

    task automatic compare();
        logic                    e_ren, e_wen, e_err, e_gv;
        logic [1:0]              e_gid;
        logic [AW-1:0]           e_addr, e_store;
        logic [CPUS-1:0]         e_iw, e_dw;
        logic [CPUS-1:0][AW-1:0] e_il, e_dl;
        e_ren = 0; e_wen = 0; e_err = 0; e_gv = 0; e_gid = 0;
        e_addr = 0; e_store = 0; e_iw = '1; e_dw = '1;
        e_il = '0; e_dl = '0;
        if (m_own) begin
            e_gv    = 1;
            e_gid   = 2'(m_core * 2 + int'(m_data));
            e_addr  = m_data ? daddr[m_core] : iaddr[m_core];
            e_store = dstore[m_core];
            e_ren   = !m_data || (dREN[m_core] && !dWEN[m_core]);
            e_wen   = m_data && dWEN[m_core];
            if (ramstate == ERROR) e_err = 1;
            else if (owner_req() && ramstate == ACCESS) begin
                if (m_data) begin
                    e_dw[m_core] = 0; e_dl[m_core] = ramload;
                end else begin
                    e_iw[m_core] = 0; e_il[m_core] = ramload;
                end
            end
        end
        check("ctl",
              64'({ramREN, ramWEN, iwait, dwait, grant_valid, grant_id, bus_err}),
              64'({e_ren, e_wen, e_iw, e_dw, e_gv, e_gid, e_err}));
        check("ramaddr", 64'(ramaddr), 64'(e_addr));
        check("ramstore", 64'(ramstore), 64'(e_store));
        check("iload", 64'(iload), 64'(e_il));
        check("dload", 64'(dload), 64'(e_dl));
    endtask

    task automatic model_step();
        bit found;
        found = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (!m_own) begin
            for (int k = 0; k < CPUS; k++) begin
                int c;
                c = (m_ptr + k) % CPUS;
                if (!found && (iREN[c] | dREN[c] | dWEN[c])) begin
                    found   = 1;
                    m_own   = 1;
                    m_core  = c;
                    m_data  = dREN[c] | dWEN[c];
                    m_beats = 0;
                end
            end
        end else if (ramstate == ERROR || !owner_req()) begin
            model_release();
        end else if (ramstate == ACCESS) begin
            m_beats++;
            if (!m_data || m_beats == BURST_LEN) model_release();
        end
    endtask

    task automatic tick();
        #1;
        compare();
        model_step();
        @(negedge CLK);
    endtask

    task automatic rand_inputs();
        int r;
        for (int c = 0; c < CPUS; c++) begin
            if ($urandom_range(7) == 0) iREN[c] = ~iREN[c];
            if ($urandom_range(7) == 0) dREN[c] = ~dREN[c];
            if ($urandom_range(11) == 0) dWEN[c] = ~dWEN[c];
            iaddr[c]  = $urandom;
            daddr[c]  = $urandom;
            dstore[c] = $urandom;
        end
        ramload = $urandom;
        r = $urandom_range(99);
        ramstate = (r < 45) ? ACCESS : (r < 75) ? BUSY : (r < 95) ? FREE : ERROR;
    endtask

    initial begin
        int expc;
        nRST = 0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;
        model_reset();
        #1;
        check("rst_ctl",
              64'({ramREN, ramWEN, iwait, dwait, grant_valid, grant_id, bus_err}),
              64'({1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0}));
        check("rst_load", 64'(iload | dload), 64'(0));
        @(negedge CLK);
        nRST = 1;

        // single fetch with two BUSY cycles
        iREN = 2'b01; iaddr[0] = 32'h100; ramstate = BUSY; ramload = 32'h1234;
        tick();
        #1 check("fetch_en", 64'({ramREN, ramaddr}), 64'({1'b1, 32'h100}));
        tick();
        tick();
        ramstate = ACCESS;
        #1 check("fetch_iwait", 64'({iwait, iload[0]}), 64'({2'b10, 32'h1234}));
        tick();
        iREN = '0; ramstate = FREE;
        #1 check("fetch_gap", 64'({grant_valid, ramREN}), 64'(0));
        tick();
        tick();

        // data beats instruction on one core
        iREN = 2'b01; dREN = 2'b01; daddr[0] = 32'h200; ramstate = ACCESS;
        tick();
        #1 check("dpri", 64'({grant_valid, grant_id, iwait, dwait, ramaddr}),
                 64'({1'b1, 2'b01, 2'b11, 2'b10, 32'h200}));
        tick();
        #1 check("dpri_b2", 64'({iwait, dwait}), 64'({2'b11, 2'b10}));
        tick();
        iREN = '0; dREN = '0;
        tick();
        tick();

        // round robin, both cores fetching
        iREN = 2'b11; ramstate = ACCESS; expc = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (grant_valid) begin
                check("rr_core", 64'(grant_id), 64'(expc * 2));
                expc = 1 - expc;
            end
            tick();
        end
        iREN = '0;
        tick();

        // locked write burst, core 0 waits behind it
        dWEN = 2'b10; daddr[1] = 32'h40; dstore[1] = 32'hDEADBEEF;
        tick();
        iREN = 2'b01;
        #1 check("wr_b1", 64'({ramWEN, ramREN, ramstore}),
                 64'({1'b1, 1'b0, 32'hDEADBEEF}));
        tick();
        #1 check("wr_b2", 64'({ramWEN, ramstore, iwait}),
                 64'({1'b1, 32'hDEADBEEF, 2'b11}));
        tick();
        dWEN = '0;
        #1 check("wr_gap", 64'({grant_valid, ramWEN}), 64'(0));
        tick();
        tick();
        #1 check("wr_next", 64'({grant_valid, grant_id}), 64'({1'b1, 2'b00}));
        tick();
        iREN = '0;
        tick();
        tick();

        // abandoned burst after one beat
        dREN = 2'b10;
        tick();
        tick();
        dREN = '0;
        #1 check("abandon_dw", 64'(dwait), 64'(2'b11));
        tick();
        #1 check("abandon_gap", 64'(grant_valid), 64'(0));
        tick();
        tick();

        // error while granted
        dREN = 2'b01; ramstate = BUSY;
        tick();
        ramstate = ERROR;
        #1 check("err", 64'({bus_err, dwait}), 64'({1'b1, 2'b11}));
        tick();
        ramstate = FREE; dREN = '0;
        #1 check("err_pulse", 64'({bus_err, grant_valid}), 64'(0));
        tick();
        tick();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
        for (int i = 0; i < 4; i++) tick();

        // asynchronous reset in the middle of a data burst
        dREN = 2'b01; ramstate = ACCESS;
        tick();
        #2 nRST = 0;
        #1;
        check("rst_async",
              64'({ramREN, ramWEN, iwait, dwait, grant_valid, grant_id, bus_err}),
              64'({1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0}));
        check("rst_async_d", 64'({ramaddr, ramstore} | dload), 64'(0));
        model_reset();
        @(negedge CLK);
        nRST = 1; dREN = '0; iREN = 2'b10;
        tick();
        #1 check("post_rst_gid", 64'({grant_valid, grant_id}), 64'({1'b1, 2'b10}));
        tick();
        iREN = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
